// File: rtl/whack_pkg.sv
// Shared types and helpers for the whack-a-mole round sequencer.
package whack_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SHOW,
        GAP,
        DONE
    } state_t;

    // Fibonacci taps 8,6,5,4 expressed as a mask over q[7:0]
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam int MAX_HOLES = 16;

    function automatic logic [MAX_HOLES-1:0] hole_to_onehot(input logic [3:0] hole);
        logic [MAX_HOLES-1:0] oh;
        oh       = '0;
        oh[hole] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used as the mole position source.
module mole_lfsr
    import whack_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= SEED;
        else     q <= {q[6:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/whack_round_ctrl.sv
// Round sequencer: lights one mole per round, judges hits, pulses the score counter.
//
// state | meaning
// IDLE  | waiting for start after reset, outputs quiet
// ARM   | one cycle: clear score, load round count
// SHOW  | mole lit, waiting for matching hit or timeout
// GAP   | dark interval between rounds
// DONE  | game over, waiting for start
module whack_round_ctrl
    import whack_pkg::*;
#(
    parameter int         N_HOLES     = 8,
    parameter int         SHOW_TICKS  = 20,
    parameter int         GAP_TICKS   = 5,
    parameter int         GAME_ROUNDS = 30,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic [N_HOLES-1:0] hit,
    output logic [N_HOLES-1:0] mole,
    output logic               add_score,
    output logic               score_clear,
    output logic [7:0]         rounds_left,
    output logic               playing,
    output logic               game_over
);

    localparam int         HB       = $clog2(N_HOLES);
    localparam logic [7:0] SHOW_T   = 8'(SHOW_TICKS);
    localparam logic [7:0] GAP_T    = 8'(GAP_TICKS);
    localparam logic [7:0] ROUNDS_T = 8'(GAME_ROUNDS);

    state_t          state;
    logic [7:0]      timer;
    logic [HB-1:0]   prev_hole;
    logic [7:0]      lfsr_q;
    logic [HB-1:0]   cand;
    logic [HB-1:0]   next_hole;
    logic            hit_match;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Bump the candidate by one when it would repeat the previous hole
    always_comb begin
        cand      = HB'(lfsr_q % N_HOLES);
        next_hole = (cand == prev_hole) ? cand + 1'b1 : cand;
        hit_match = |(hit & mole);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mole        <= '0;
            add_score   <= 1'b0;
            score_clear <= 1'b0;
            rounds_left <= '0;
            playing     <= 1'b0;
            game_over   <= 1'b0;
            timer       <= '0;
            prev_hole   <= '0;
        end else begin
            add_score   <= 1'b0;
            score_clear <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= ARM;
                        score_clear <= 1'b1;
                        rounds_left <= ROUNDS_T;
                        playing     <= 1'b1;
                        game_over   <= 1'b0;
                    end
                end
                ARM: begin
                    state     <= SHOW;
                    mole      <= N_HOLES'(hole_to_onehot(4'(next_hole)));
                    timer     <= SHOW_T;
                    prev_hole <= next_hole;
                end
                SHOW: begin
                    // A matching hit takes priority over the expiring tick
                    if (hit_match || (tick && timer == 8'd1)) begin
                        add_score   <= hit_match;
                        mole        <= '0;
                        timer       <= GAP_T;
                        rounds_left <= rounds_left - 8'd1;
                        state       <= GAP;
                    end else if (tick) begin
                        timer <= timer - 8'd1;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (timer == 8'd1) begin
                            if (rounds_left == 8'd0) begin
                                state     <= DONE;
                                playing   <= 1'b0;
                                game_over <= 1'b1;
                            end else begin
                                state     <= SHOW;
                                mole      <= N_HOLES'(hole_to_onehot(4'(next_hole)));
                                timer     <= SHOW_T;
                                prev_hole <= next_hole;
                            end
                        end else begin
                            timer <= timer - 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/whack_round_ctrl.md
# whack_round_ctrl

Game sequencer for the whack-a-mole score path. It runs a fixed number of rounds and lights one mole per round from a pseudo-random source. It judges player hits and drives the two-digit BCD score counter: a one-cycle `add_score` pulse per valid hit, and a one-cycle `score_clear` at game start wired to the counter's `pb_clear_op`. It sits between the debounced push-button/tick logic and the score counter and LED drivers.

## Interface
Parameters:
- `N_HOLES`, 8: number of moles/buttons; power of two, 2..16.
- `SHOW_TICKS`, 20: ticks a mole stays lit, 1..255.
- `GAP_TICKS`, 5: dark ticks between rounds, 1..255.
- `GAME_ROUNDS`, 30: rounds per game, 1..255.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `tick`, in, 1: one-cycle timebase enable (e.g. 10 Hz).
- `start`, in, 1: one-cycle start pulse (debounced).
- `hit`, in, N_HOLES: one-cycle button pulses, one bit per hole.
- `mole`, out, N_HOLES: one-hot lit mole, or all-zero.
- `add_score`, out, 1: one-cycle pulse to the score counter.
- `score_clear`, out, 1: one-cycle pulse to the counter's `pb_clear_op`.
- `rounds_left`, out, 8: remaining rounds including the current one.
- `playing`, out, 1: high in ARM/SHOW/GAP.
- `game_over`, out, 1: high in DONE.

## Operation
- Reset values: state IDLE, `mole`=0, `add_score`=0, `score_clear`=0, `rounds_left`=0, `playing`=0, `game_over`=0, LFSR=`LFSR_SEED`, timer=0, previous-hole register=0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4 (x^8+x^6+x^5+x^4+1), shifts every clk in every state except reset.
- Hole choice: candidate = low log2(N_HOLES) LFSR bits. If the candidate equals the previous hole, use candidate+1 modulo N_HOLES. This guarantees no mole repeats in consecutive rounds.
- IDLE: outputs quiet. `start` moves to ARM.
- ARM (1 cycle): `score_clear`=1, `rounds_left`=GAME_ROUNDS, then go to SHOW. On SHOW entry, load a new hole into `mole` and the timer with SHOW_TICKS.
- SHOW:
  - Any `hit` bit matching the lit `mole` bit scores: `add_score` pulses, `mole` clears, go to GAP.
  - Hits on other holes are ignored; no penalty.
  - Otherwise `tick` decrements the timer. When the timer reaches 0, `mole` clears and the FSM goes to GAP with no score.
- GAP:
  - Entry loads the timer with GAP_TICKS and decrements `rounds_left`.
  - Each `tick` decrements the timer. At 0: if `rounds_left`=0 go to DONE, else go to SHOW with a new hole.
- DONE: `game_over`=1, `mole`=0. `start` goes to ARM; `game_over` drops on leaving DONE.
- `start` is ignored in ARM, SHOW and GAP.
- A matching hit and an expiring tick in the same cycle: the hit wins and scores.
- Multiple `hit` bits in one cycle: score if any bit matches `mole`; at most one `add_score` per round.
- `rst` asserted at any point: immediate return to reset values, including mid-round. A pulse in flight on `add_score` or `score_clear` is truncated.

## Timing
- All outputs are registered.
- `add_score` is high exactly one cycle, on the cycle after `hit` is sampled. `mole` clears on that same cycle.
- `score_clear` is high the cycle after `start` is sampled in IDLE/DONE. The first `mole` lights one cycle later.
- Timeout: `mole` clears on the cycle after the SHOW_TICKS-th `tick` sampled in SHOW.
- The next mole lights on the cycle after the GAP_TICKS-th `tick` in GAP.
- `rounds_left` updates on the cycle GAP is entered.
- No `add_score` is ever generated outside SHOW.

## Structure
- Shared package `whack_pkg`:
  - state enum (IDLE, ARM, SHOW, GAP, DONE);
  - LFSR tap constant;
  - the `hole_to_onehot` function.
- Sub-module `mole_lfsr`: 8-bit LFSR with seed parameter and `q` output, free-running. The no-repeat adjustment stays in the controller.

## Test plan
- Reset, then `start` -> `score_clear` high 1 cycle, `rounds_left`=30, exactly one `mole` bit set 2 cycles after `start`.
- Correct hit in SHOW -> `add_score` one cycle later for one cycle, `mole`=0, `rounds_left` 30->29; a second hit in GAP gives no pulse.
- Wrong-hole hit plus 20 ticks -> no `add_score`, `mole` clears after the 20th tick.
- Matching hit coincident with the 20th tick -> `add_score`=1 once.
- GAME_ROUNDS=3 with all hits -> exactly 3 `add_score` pulses, `game_over`=1, `mole`=0. A later `start` restarts with `score_clear`.
- 200 rounds -> never the same hole twice in a row. `rst` pulsed mid-SHOW -> all outputs 0, state IDLE, next `start` behaves as after power-up.
